// File: rtl/conv_requant_pipe.sv
// Per-channel requantiser: bias add, fixed-point scale, round, shift, saturate/ReLU.
// Three register stages advance together under a single enable driven by the output handshake.
module conv_requant_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT       = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int NUM_CH      = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [BIAS_WIDTH-1:0]  cfg_bias,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic                   relu_en,
  input  logic                   ch_clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  sum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic [CH_W-1:0]        out_ch
);

  localparam int BW = ((DATA_WIDTH > BIAS_WIDTH) ? DATA_WIDTH : BIAS_WIDTH) + 1;
  localparam int PW = BW + SCALE_WIDTH;
  localparam logic signed [PW-1:0] MAX_V = PW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;
  localparam logic signed [PW-1:0] RND_V = PW'(1) << (SHIFT - 1);

  logic [BIAS_WIDTH-1:0]  r_bias  [NUM_CH];
  logic [SCALE_WIDTH-1:0] r_scale [NUM_CH];

  logic                   w_en;
  logic                   w_acc;
  logic [CH_W-1:0]        w_ch;
  logic [CH_W-1:0]        r_cnt;
  logic [BIAS_WIDTH-1:0]  w_bias_rd;
  logic [SCALE_WIDTH-1:0] w_scale_rd;
  logic signed [BW-1:0]   w_b;
  logic signed [PW-1:0]   w_p;
  logic signed [PW-1:0]   w_rnd;
  logic signed [PW-1:0]   w_r;
  logic [OUT_WIDTH-1:0]   w_sat;

  logic                   r_s1_valid;
  logic signed [BW-1:0]   r_s1_b;
  logic [SCALE_WIDTH-1:0] r_s1_scale;
  logic [CH_W-1:0]        r_s1_ch;
  logic                   r_s1_relu;
  logic                   r_s2_valid;
  logic signed [PW-1:0]   r_s2_p;
  logic [CH_W-1:0]        r_s2_ch;
  logic                   r_s2_relu;
  logic                   r_out_valid;
  logic [OUT_WIDTH-1:0]   r_data_out;
  logic [CH_W-1:0]        r_out_ch;

  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;
  assign w_acc    = in_valid & w_en;
  assign w_ch     = ch_clr ? '0 : r_cnt;

  // The table is read combinationally so a same-cycle write lands after the beat has taken the old entry.
  assign w_bias_rd  = r_bias[w_ch];
  assign w_scale_rd = r_scale[w_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_bias[i]  <= '0;
        r_scale[i] <= SCALE_WIDTH'(1) << SHIFT;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_addr == CH_W'(i)) begin
          r_bias[i]  <= cfg_bias;
          r_scale[i] <= cfg_scale;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= (w_ch == CH_W'(NUM_CH - 1)) ? '0 : w_ch + 1'b1;
    end
  end

  assign w_b = $signed({{(BW - DATA_WIDTH){sum_in[DATA_WIDTH-1]}}, sum_in})
             + $signed({{(BW - BIAS_WIDTH){w_bias_rd[BIAS_WIDTH-1]}}, w_bias_rd});

  assign w_p = $signed({{SCALE_WIDTH{r_s1_b[BW-1]}}, r_s1_b})
             * $signed({{BW{r_s1_scale[SCALE_WIDTH-1]}}, r_s1_scale});

  // Product magnitude stays below 2^(PW-2), so adding the rounding constant cannot wrap.
  assign w_rnd = r_s2_p + RND_V;
  assign w_r   = w_rnd >>> SHIFT;

  always_comb begin
    w_sat = w_r[OUT_WIDTH-1:0];
    if (w_r > MAX_V) begin
      w_sat = MAX_V[OUT_WIDTH-1:0];
    end else if (r_s2_relu && w_r[PW-1]) begin
      w_sat = '0;
    end else if (!r_s2_relu && (w_r < MIN_V)) begin
      w_sat = MIN_V[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_b      <= '0;
      r_s1_scale  <= '0;
      r_s1_ch     <= '0;
      r_s1_relu   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_p      <= '0;
      r_s2_ch     <= '0;
      r_s2_relu   <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_out_ch    <= '0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_b      <= w_b;
      r_s1_scale  <= w_scale_rd;
      r_s1_ch     <= w_ch;
      r_s1_relu   <= relu_en;
      r_s2_valid  <= r_s1_valid;
      r_s2_p      <= w_p;
      r_s2_ch     <= r_s1_ch;
      r_s2_relu   <= r_s1_relu;
      r_out_valid <= r_s2_valid;
      r_data_out  <= w_sat;
      r_out_ch    <= r_s2_ch;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_conv_requant_pipe.sv
// Directed bench for conv_requant_pipe with a 4-entry table; expected values are worked by hand.
module tb_conv_requant_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_bias = '0;
  logic [15:0] cfg_scale = '0;
  logic        relu_en = 1'b0;
  logic        ch_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sum_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  data_out;
  logic [1:0]  out_ch;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  int q_d[$];
  int q_c[$];

  conv_requant_pipe #(.NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .cfg_scale(cfg_scale), .relu_en(relu_en), .ch_clr(ch_clr), .in_valid(in_valid),
    .in_ready(in_ready), .sum_in(sum_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      q_d.push_back(int'($signed(data_out)));
      q_c.push_back(int'(out_ch));
    end
  end

  task automatic cfg_write(input int addr, input int bias, input int scale);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_bias = bias; cfg_scale = 16'(scale);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_beat(input int s, input logic clr, input logic relu,
                          output int d, output int c, output int lat);
    @(posedge clk); #1;
    sum_in = s; ch_clr = clr; relu_en = relu; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ch_clr = 1'b0;
    d = 0; c = 0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        d = int'($signed(data_out)); c = int'(out_ch); lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b expected 0", out_valid); end
    n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL rst_data_out got %0d expected 0", data_out); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL rst_out_ch got %0d expected 0", out_ch); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %0b expected 1", in_ready); end
    $display("reset: released");
  endtask

  task automatic test_identity();
    int d, c, lat;
    cfg_write(0, 27, 256);
    run_beat(100, 1'b1, 1'b0, d, c, lat);
    $display("identity: sum=100 bias=27 -> data=%0d ch=%0d lat=%0d", d, c, lat);
    n_cmp++; if (d !== 127) begin n_bad++; $display("FAIL id_b27 got %0d expected 127", d); end
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL id_ch got %0d expected 0", c); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL id_latency got %0d expected 2", lat); end
    cfg_write(0, 28, 256);
    run_beat(100, 1'b1, 1'b0, d, c, lat);
    $display("identity: sum=100 bias=28 -> data=%0d", d);
    n_cmp++; if (d !== 127) begin n_bad++; $display("FAIL id_b28_sat got %0d expected 127", d); end
    cfg_write(0, -28, 256);
    run_beat(100, 1'b1, 1'b0, d, c, lat);
    $display("identity: sum=100 bias=-28 -> data=%0d", d);
    n_cmp++; if (d !== 72) begin n_bad++; $display("FAIL id_bneg got %0d expected 72", d); end
  endtask

  task automatic test_relu();
    int d, c, lat;
    int vs[5] = '{-50, -50, -500, 300, -500};
    logic rl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int ex[5] = '{0, -50, -128, 127, 0};
    cfg_write(0, 0, 256);
    for (int k = 0; k < 5; k++) begin
      run_beat(vs[k], 1'b1, rl[k], d, c, lat);
      $display("relu: sum=%0d relu_en=%0b -> data=%0d", vs[k], rl[k], d);
      n_cmp++; if (d !== ex[k]) begin n_bad++; $display("FAIL relu_%0d got %0d expected %0d", k, d, ex[k]); end
    end
  endtask

  task automatic test_rounding();
    int d, c, lat;
    int vs[4] = '{3, -3, 1, -1};
    int ex[4] = '{2, -1, 1, 0};
    cfg_write(0, 0, 128);
    for (int k = 0; k < 4; k++) begin
      run_beat(vs[k], 1'b1, 1'b0, d, c, lat);
      $display("round: sum=%0d scale=128 -> data=%0d", vs[k], d);
      n_cmp++; if (d !== ex[k]) begin n_bad++; $display("FAIL round_%0d got %0d expected %0d", k, d, ex[k]); end
    end
  endtask

  task automatic test_table_write();
    int d, c, lat;
    cfg_write(0, 0, 256);
    @(posedge clk); #1;
    in_valid = 1'b1; sum_in = 10; ch_clr = 1'b1; relu_en = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_bias = 50; cfg_scale = 16'd256;
    @(posedge clk); #1;
    in_valid = 1'b0; ch_clr = 1'b0; cfg_we = 1'b0;
    d = -999;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin d = int'($signed(data_out)); break; end
      @(posedge clk); #1;
    end
    $display("table: same-cycle write, sum=10 -> data=%0d", d);
    n_cmp++; if (d !== 10) begin n_bad++; $display("FAIL wr_old got %0d expected 10", d); end
    run_beat(10, 1'b1, 1'b0, d, c, lat);
    $display("table: after write, sum=10 -> data=%0d", d);
    n_cmp++; if (d !== 60) begin n_bad++; $display("FAIL wr_new got %0d expected 60", d); end
  endtask

  task automatic test_channels();
    int exp_c[2][6] = '{'{0, 1, 2, 3, 0, 1}, '{0, 1, 2, 0, 1, 2}};
    logic [5:0] clr_mask[2] = '{6'b000001, 6'b001001};
    for (int k = 0; k < 4; k++) cfg_write(k, k, 256);
    for (int r = 0; r < 2; r++) begin
      q_d.delete(); q_c.delete();
      mon_en = 1'b1; out_ready = 1'b1; relu_en = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
        in_valid = 1'b1; sum_in = 10; ch_clr = clr_mask[r][k];
        @(posedge clk); #1;
      end
      in_valid = 1'b0; ch_clr = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      mon_en = 1'b0;
      n_cmp++; if (q_d.size() !== 6) begin n_bad++; $display("FAIL chan%0d_count got %0d expected 6", r, q_d.size()); end
      for (int k = 0; k < 6 && k < q_d.size(); k++) begin
        $display("chan run %0d: beat %0d -> ch=%0d data=%0d", r, k, q_c[k], q_d[k]);
        n_cmp++; if (q_c[k] !== exp_c[r][k]) begin n_bad++; $display("FAIL chan%0d_ch%0d got %0d expected %0d", r, k, q_c[k], exp_c[r][k]); end
        n_cmp++; if (q_d[k] !== 10 + exp_c[r][k]) begin n_bad++; $display("FAIL chan%0d_data%0d got %0d expected %0d", r, k, q_d[k], 10 + exp_c[r][k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    q_d.delete(); q_c.delete();
    mon_en = 1'b1; relu_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        int idx;
        logic acc;
        idx = 0;
        for (int t = 0; t < 60 && idx < 4; t++) begin
          in_valid = 1'b1; sum_in = 20 + idx; ch_clr = (idx == 0);
          @(negedge clk); acc = in_ready;
          @(posedge clk); #1;
          if (acc) idx++;
        end
        in_valid = 1'b0; ch_clr = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d got %0b expected 0", s, in_ready); end
          n_cmp++; if (data_out !== 8'd20 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d got data=%0d valid=%0b expected data=20 valid=1", s, data_out, out_valid); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++; if (q_d.size() !== 4) begin n_bad++; $display("FAIL bp_count got %0d expected 4", q_d.size()); end
    for (int k = 0; k < 4 && k < q_d.size(); k++) begin
      $display("backpressure: beat %0d -> ch=%0d data=%0d", k, q_c[k], q_d[k]);
      n_cmp++; if (q_d[k] !== 20 + 2 * k || q_c[k] !== k) begin n_bad++; $display("FAIL bp_beat%0d got ch=%0d data=%0d expected ch=%0d data=%0d", k, q_c[k], q_d[k], k, 20 + 2 * k); end
    end
  endtask

  task automatic test_midstream_reset();
    int d, c, lat;
    cfg_write(0, 5, 512);
    out_ready = 1'b0; relu_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; sum_in = 37; ch_clr = 1'b1;
    @(posedge clk); #1;
    ch_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_pre_valid got %0b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %0b expected 0", out_valid); end
    n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL mrst_data got %0d expected 0", data_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready got %0b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_d.delete(); q_c.delete();
    mon_en = 1'b1; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++; if (q_d.size() !== 0) begin n_bad++; $display("FAIL mrst_stale got %0d beats expected 0", q_d.size()); end
    run_beat(37, 1'b0, 1'b0, d, c, lat);
    $display("reset: post-release sum=37 -> ch=%0d data=%0d", c, d);
    n_cmp++; if (d !== 37) begin n_bad++; $display("FAIL mrst_identity got %0d expected 37", d); end
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL mrst_cnt got %0d expected 0", c); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_relu();
    test_rounding();
    test_table_write();
    test_channels();
    test_back_to_back();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
